// File: rtl/noc_pkg.sv
// Shared definitions for the mesh NoC injection path: configure opcodes,
// injector FSM states and configure-word field positions.
package noc_pkg;

  // Opcode field of the configure word.
  localparam int         OP_W     = 2;
  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_SEND  = 2'b01;
  localparam logic [1:0] OP_ABORT = 2'b10;
  // 2'b11 is reserved and treated like "nothing to do" except that it
  // does not re-arm the injector.

  // Injector FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_BACKOFF = 3'd2,
    ST_XFER    = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  // Configure word layout is {op, dest, len}, len in the LSBs.
  localparam int LEN_LSB = 0;

  function automatic int dest_lsb(input int len_w);
    return len_w;
  endfunction

  function automatic int op_lsb(input int len_w, input int dest_w);
    return len_w + dest_w;
  endfunction

  function automatic int cfg_w(input int len_w, input int dest_w);
    return OP_W + len_w + dest_w;
  endfunction

endpackage

// File: rtl/noc_backoff_timer.sv
// Backoff timer: a load starts a BACKOFF-cycle interval; done is high in the
// last cycle of that interval. clear cancels a running interval.
module noc_backoff_timer
  import noc_pkg::*;
#(
  parameter int BACKOFF = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic done
);

  localparam int CNT_W  = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
  localparam int LOAD_V = (BACKOFF > 0) ? BACKOFF - 1 : 0;

  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // Down-counter: loaded with BACKOFF-1 so that done lands on cycle BACKOFF.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (clear) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      busy_q <= 1'b1;
      cnt_q  <= CNT_W'(LOAD_V);
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/noc_path_injector.sv
// Per-processor injection controller: turns a level-held configure word into
// a path request, retries with backoff on block, streams a counted burst of
// flits once granted, then releases the path.
//
// Flit handshake: a flit transfers on every rising clock edge where
// flit_valid && flit_ready. While flit_valid is high, flit_data is held
// stable until that transfer happens; flit_valid never depends on
// flit_ready.
module noc_path_injector
  import noc_pkg::*;
#(
  parameter int NUM_NODES = 4,
  parameter int NODE_ID   = 0,
  parameter int DEST_W    = 2,
  parameter int LEN_W     = 7,
  parameter int FLIT_W    = 16,
  parameter int BACKOFF   = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [OP_W+DEST_W+LEN_W-1:0]       configure,
  input  logic                               path_grant,
  input  logic                               path_block,
  input  logic                               flit_ready,
  output logic                               ready,
  output logic                               path_req,
  output logic [DEST_W-1:0]                  path_dest,
  output logic                               flit_valid,
  output logic [FLIT_W-1:0]                  flit_data,
  output logic                               path_release,
  output logic                               error,
  output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt,
  output logic [2:0]                         dbg_state
);

  localparam int RW       = $clog2(MAX_RETRY + 1);
  localparam int CFG_W    = cfg_w(LEN_W, DEST_W);
  localparam int DEST_LSB = dest_lsb(LEN_W);
  localparam int OP_LSB   = op_lsb(LEN_W, DEST_W);

  // Configure word fields.
  logic [OP_W-1:0]   cfg_op;
  logic [DEST_W-1:0] cfg_dest;
  logic [LEN_W-1:0]  cfg_len;
  int                cfg_dest_int;
  logic              dest_bad;

  assign cfg_op   = configure[OP_LSB +: OP_W];
  assign cfg_dest = configure[DEST_LSB +: DEST_W];
  assign cfg_len  = configure[LEN_LSB +: LEN_W];

  // A send to ourselves or to a node outside the mesh is rejected.
  always_comb begin
    cfg_dest_int = int'(cfg_dest);
    dest_bad     = (cfg_dest == DEST_W'(NODE_ID)) || (cfg_dest_int >= NUM_NODES);
  end

  // FSM and datapath registers.
  state_e            state_q, state_n;
  logic              arm_q, arm_n;
  logic              error_q, error_n;
  logic [RW-1:0]     retry_q, retry_n;
  logic [DEST_W-1:0] dest_q, dest_n;
  logic [LEN_W-1:0]  count_q, count_n;
  logic              tmr_load, tmr_clear, tmr_done;

  noc_backoff_timer #(.BACKOFF(BACKOFF)) u_backoff (
    .clock (clock),
    .reset (reset),
    .load  (tmr_load),
    .clear (tmr_clear),
    .done  (tmr_done)
  );

  // State register and the registered message context.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      arm_q   <= 1'b1;
      error_q <= 1'b0;
      retry_q <= '0;
      dest_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_n;
      arm_q   <= arm_n;
      error_q <= error_n;
      retry_q <= retry_n;
      dest_q  <= dest_n;
      count_q <= count_n;
    end
  end

  // Next-state logic. Abort is evaluated ahead of any other event; grant
  // beats block when both arrive together.
  always_comb begin
    state_n   = state_q;
    arm_n     = arm_q;
    error_n   = error_q;
    retry_n   = retry_q;
    dest_n    = dest_q;
    count_n   = count_q;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;

    // Seeing an idle opcode re-arms, so a held send word fires only once.
    if (cfg_op == OP_NONE) arm_n = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cfg_op == OP_SEND && arm_q) begin
          arm_n = 1'b0;
          if (dest_bad) begin
            error_n = 1'b1;
          end else if (cfg_len == '0) begin
            error_n = 1'b0;
          end else begin
            dest_n  = cfg_dest;
            count_n = cfg_len;
            error_n = 1'b0;
            retry_n = '0;
            state_n = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (cfg_op == OP_ABORT) begin
          state_n = ST_IDLE;
        end else if (path_grant) begin
          state_n = ST_XFER;
        end else if (path_block) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_n  = retry_q + RW'(1);
            tmr_load = 1'b1;
            state_n  = ST_BACKOFF;
          end else begin
            error_n = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      ST_BACKOFF: begin
        if (cfg_op == OP_ABORT) begin
          tmr_clear = 1'b1;
          state_n   = ST_IDLE;
        end else if (tmr_done) begin
          state_n = ST_REQ;
        end
      end
      ST_XFER: begin
        if (cfg_op == OP_ABORT) begin
          state_n = ST_RELEASE;
        end else if (flit_ready) begin
          count_n = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) state_n = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state.
  assign ready        = (state_q == ST_IDLE);
  assign path_req     = (state_q == ST_REQ);
  assign flit_valid   = (state_q == ST_XFER);
  assign path_release = (state_q == ST_RELEASE);
  assign path_dest    = dest_q;
  assign error        = error_q;
  assign retry_cnt    = retry_q;
  assign dbg_state    = state_q;

  // Flit payload {zero pad, NODE_ID, remaining count}, zero when no flit.
  always_comb begin
    flit_data = '0;
    if (flit_valid) begin
      flit_data[LEN_W-1:0]       = count_q;
      flit_data[LEN_W +: DEST_W] = DEST_W'(NODE_ID);
    end
  end

endmodule

// File: tb/tb_noc_path_injector.sv
// Directed bench for noc_path_injector with a flit scoreboard.
module tb_noc_path_injector;
  import noc_pkg::*;

  localparam int NUM_NODES = 4;
  localparam int NODE_ID   = 0;
  localparam int DEST_W    = 2;
  localparam int LEN_W     = 7;
  localparam int FLIT_W    = 16;
  localparam int BACKOFF   = 8;
  localparam int MAX_RETRY = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic [10:0]       configure;
  logic              path_grant, path_block, flit_ready;
  logic              ready, path_req, flit_valid, path_release, error;
  logic [DEST_W-1:0] path_dest;
  logic [FLIT_W-1:0] flit_data;
  logic [1:0]        retry_cnt;
  logic [2:0]        dbg_state;

  noc_path_injector #(
    .NUM_NODES(NUM_NODES), .NODE_ID(NODE_ID), .DEST_W(DEST_W), .LEN_W(LEN_W),
    .FLIT_W(FLIT_W), .BACKOFF(BACKOFF), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clock(clock), .reset(reset), .configure(configure),
    .path_grant(path_grant), .path_block(path_block), .flit_ready(flit_ready),
    .ready(ready), .path_req(path_req), .path_dest(path_dest),
    .flit_valid(flit_valid), .flit_data(flit_data), .path_release(path_release),
    .error(error), .retry_cnt(retry_cnt), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected flits in transfer order, plus event counters.
  logic [FLIT_W-1:0] exp_q[$];
  int   n_flit = 0;
  int   n_rel  = 0;
  int   n_req  = 0;
  logic req_prev = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      if (flit_valid && flit_ready) begin
        n_flit++;
        if (exp_q.size() > 0) check("flit_data", flit_data, exp_q.pop_front());
        else                  check("flit_unexpected", flit_data, 32'hffff_ffff);
      end
      if (path_release) n_rel++;
      if (path_req && !req_prev) n_req++;
      req_prev = path_req;
    end else begin
      req_prev = 1'b0;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_cfg(input logic [1:0] op, input logic [1:0] dest, input logic [6:0] len);
    configure = {op, dest, len};
  endtask

  task automatic push_flit(input int c);
    exp_q.push_back({7'd0, 2'(NODE_ID), 7'(c)});
  endtask

  task automatic push_flits(input int len);
    for (int c = len; c >= 1; c--) push_flit(c);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!ready && n < 50) begin
      tick();
      n++;
    end
    check(tag, ready, 1);
  endtask

  // Block the pending request, then measure how long path_req stays low.
  task automatic do_block(input int exp_retry);
    int low;
    path_block = 1'b1;
    tick();
    path_block = 1'b0;
    check("retry_after_block", retry_cnt, exp_retry);
    low = 0;
    while (!path_req && low < 30) begin
      low++;
      tick();
    end
    check("backoff_len", low, BACKOFF);
  endtask

  int f0, r0, q0;
  int rdy_pat[5] = '{1, 0, 0, 1, 1};
  int dat_pat[5] = '{3, 2, 2, 2, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    configure  = '0;
    path_grant = 1'b0;
    path_block = 1'b0;
    flit_ready = 1'b1;
    reset      = 1'b0;
    #10;
    check("rst_ready", ready, 1);
    check("rst_req", path_req, 0);
    check("rst_valid", flit_valid, 0);
    check("rst_release", path_release, 0);
    check("rst_error", error, 0);
    check("rst_retry", retry_cnt, 0);
    check("rst_dest", path_dest, 0);
    check("rst_data", flit_data, 0);
    #6 reset = 1'b1;
    tick();

    // Basic send: held 3 cycles, grant on first request cycle.
    f0 = n_flit; r0 = n_rel; q0 = n_req;
    drive_cfg(OP_SEND, 2'd1, 7'd5);
    push_flits(5);
    tick();
    check("t1_req_latency", path_req, 1);
    check("t1_ready_low", ready, 0);
    check("t1_dest", path_dest, 1);
    path_grant = 1'b1;
    tick();
    path_grant = 1'b0;
    check("t1_state_xfer", dbg_state, ST_XFER);
    check("t1_first_valid", flit_valid, 1);
    check("t1_first_data", flit_data, 5);
    tick();
    configure = '0;
    check("t1_data4", flit_data, 4);
    for (int i = 3; i >= 1; i--) begin
      tick();
      check("t1_data_seq", flit_data, i);
    end
    tick();
    check("t1_release", path_release, 1);
    check("t1_valid_off", flit_valid, 0);
    tick();
    check("t1_release_once", path_release, 0);
    check("t1_ready_back", ready, 1);
    repeat (3) tick();
    check("t1_req_episodes", n_req - q0, 1);
    check("t1_flits", n_flit - f0, 5);
    check("t1_releases", n_rel - r0, 1);
    check("t1_error", error, 0);

    // Retry: two blocks then grant.
    f0 = n_flit; r0 = n_rel; q0 = n_req;
    drive_cfg(OP_SEND, 2'd2, 7'd3);
    push_flits(3);
    tick();
    configure = '0;
    check("t2_req", path_req, 1);
    do_block(1);
    do_block(2);
    path_grant = 1'b1;
    tick();
    path_grant = 1'b0;
    check("t2_xfer", flit_valid, 1);
    wait_idle("t2_idle");
    check("t2_retry", retry_cnt, 2);
    check("t2_error", error, 0);
    check("t2_flits", n_flit - f0, 3);
    check("t2_releases", n_rel - r0, 1);
    check("t2_req_episodes", n_req - q0, 3);

    // Retry exhaustion: four blocks with MAX_RETRY=3.
    f0 = n_flit; r0 = n_rel; q0 = n_req;
    drive_cfg(OP_SEND, 2'd3, 7'd4);
    tick();
    configure = '0;
    do_block(1);
    do_block(2);
    do_block(3);
    path_block = 1'b1;
    tick();
    path_block = 1'b0;
    check("t3_error", error, 1);
    check("t3_ready", ready, 1);
    check("t3_req_off", path_req, 0);
    check("t3_retry", retry_cnt, 3);
    repeat (3) tick();
    check("t3_no_flits", n_flit - f0, 0);
    check("t3_no_release", n_rel - r0, 0);
    check("t3_req_episodes", n_req - q0, 4);

    // Backpressure, with configure held past completion (no resend).
    f0 = n_flit; r0 = n_rel; q0 = n_req;
    drive_cfg(OP_SEND, 2'd1, 7'd3);
    push_flits(3);
    tick();
    check("t4_error_cleared", error, 0);
    path_grant = 1'b1;
    tick();
    path_grant = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t4_hold", flit_data, dat_pat[k]);
      flit_ready = 1'(rdy_pat[k]);
      tick();
    end
    check("t4_release", path_release, 1);
    flit_ready = 1'b1;
    repeat (4) tick();
    check("t4_ready", ready, 1);
    check("t4_single_send", n_req - q0, 1);
    check("t4_flits", n_flit - f0, 3);
    configure = '0;
    tick();

    // Abort after 2 of 5 flits.
    f0 = n_flit; r0 = n_rel;
    drive_cfg(OP_SEND, 2'd2, 7'd5);
    push_flit(5);
    push_flit(4);
    tick();
    configure  = '0;
    path_grant = 1'b1;
    tick();
    path_grant = 1'b0;
    check("t5a_data5", flit_data, 5);
    tick();
    check("t5a_data4", flit_data, 4);
    tick();
    check("t5a_data3", flit_data, 3);
    drive_cfg(OP_ABORT, 2'd0, 7'd0);
    flit_ready = 1'b0;
    tick();
    check("t5a_release", path_release, 1);
    check("t5a_valid_off", flit_valid, 0);
    tick();
    check("t5a_ready", ready, 1);
    configure  = '0;
    flit_ready = 1'b1;
    tick();
    check("t5a_flits", n_flit - f0, 2);
    check("t5a_releases", n_rel - r0, 1);

    // Grant and block in the same cycle.
    f0 = n_flit;
    drive_cfg(OP_SEND, 2'd3, 7'd2);
    push_flits(2);
    tick();
    configure  = '0;
    path_grant = 1'b1;
    path_block = 1'b1;
    tick();
    path_grant = 1'b0;
    path_block = 1'b0;
    check("t5b_xfer", flit_valid, 1);
    check("t5b_retry", retry_cnt, 0);
    wait_idle("t5b_idle");
    check("t5b_flits", n_flit - f0, 2);
    check("t5b_error", error, 0);

    // Invalid destination, then zero length.
    q0 = n_req;
    drive_cfg(OP_SEND, 2'(NODE_ID), 7'd4);
    tick();
    configure = '0;
    check("t6a_error", error, 1);
    check("t6a_ready", ready, 1);
    check("t6a_no_req", path_req, 0);
    tick();
    drive_cfg(OP_SEND, 2'd1, 7'd0);
    tick();
    configure = '0;
    check("t6a_len0_error_clr", error, 0);
    check("t6a_len0_ready", ready, 1);
    tick();
    check("t6a_no_req_episode", n_req - q0, 0);

    // Reset asserted mid-transfer.
    f0 = n_flit; r0 = n_rel;
    drive_cfg(OP_SEND, 2'd1, 7'd6);
    push_flit(6);
    push_flit(5);
    tick();
    configure  = '0;
    path_grant = 1'b1;
    tick();
    path_grant = 1'b0;
    check("t6b_data6", flit_data, 6);
    tick();
    check("t6b_data5", flit_data, 5);
    tick();
    flit_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("t6b_ready", ready, 1);
    check("t6b_req", path_req, 0);
    check("t6b_valid", flit_valid, 0);
    check("t6b_data", flit_data, 0);
    check("t6b_release", path_release, 0);
    check("t6b_error", error, 0);
    check("t6b_retry", retry_cnt, 0);
    check("t6b_dest", path_dest, 0);
    #10 reset = 1'b1;
    flit_ready = 1'b1;
    tick();
    tick();
    check("t6b_idle", ready, 1);
    check("t6b_no_release", n_rel - r0, 0);
    check("t6b_flits", n_flit - f0, 2);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
